// File: rtl/rom_burst_rd_if.sv
// rom_burst_rd_if: bundles the burst request/status signals, the ROM read bus
// and the output stream of the ROM burst reader.
// The chksum_o member exists only when ROM_BURST_RD_CHKSUM_EN is defined.
// master: the burst reader itself. slave: the side that requests bursts,
// owns the ROM and consumes the stream.
interface rom_burst_rd_if #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
) ();

  // burst request and status
  logic                  start_i;
  logic [Addr_Width-1:0] base_addr_i;
  logic [Addr_Width:0]   len_i;
  logic                  busy_o;
  logic                  done_o;

  // ROM read bus (enables are low active)
  logic                  rom_cen_o;
  logic                  rom_oen_o;
  logic [Addr_Width-1:0] rom_addr_o;
  logic [Word_Width-1:0] rom_data_i;

  // output stream
  logic                  val_o;
  logic                  rdy_i;
  logic [Word_Width-1:0] data_o;

`ifdef ROM_BURST_RD_CHKSUM_EN
  logic [Word_Width-1:0] chksum_o;
`endif

  modport master (
    input  start_i, base_addr_i, len_i, rom_data_i, rdy_i,
    output busy_o, done_o, rom_cen_o, rom_oen_o, rom_addr_o, val_o, data_o
`ifdef ROM_BURST_RD_CHKSUM_EN
    , output chksum_o
`endif
  );

  modport slave (
    output start_i, base_addr_i, len_i, rom_data_i, rdy_i,
    input  busy_o, done_o, rom_cen_o, rom_oen_o, rom_addr_o, val_o, data_o
`ifdef ROM_BURST_RD_CHKSUM_EN
    , input chksum_o
`endif
  );

endinterface

// File: rtl/rom_burst_rd.sv
// rom_burst_rd: fetches len_i consecutive words from a single-port synchronous
// ROM (low-active chip/output enable, data one cycle after the address) and
// presents them on a valid/ready stream. A 3-entry FIFO absorbs the ROM
// latency so the stream keeps one word per cycle under backpressure.
// Optional: define ROM_BURST_RD_CHKSUM_EN to add chksum_o, the modular sum of
// all words transferred in the current burst.
module rom_burst_rd #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
) (
  input  logic           clk,
  input  logic           rst,
  rom_burst_rd_if.master bus
);

  localparam int Fifo_Depth = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // control state
  state_t                state;
  logic [Addr_Width-1:0] addr;       // next ROM address to issue
  logic [Addr_Width:0]   remaining;  // reads still to issue
  logic                  inflight;   // a read was issued last cycle
  logic                  oen_hold;   // keeps output enable low between issues
  logic                  busy;
  logic                  done;

  // output FIFO
  logic [Word_Width-1:0] fifo_mem [Fifo_Depth];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            fifo_cnt;

  // per-cycle decisions
  logic [2:0] pending;
  logic       accept;
  logic       issue;
  logic       push;
  logic       pop;
  logic       finish;

  // Circular pointer advance over the 3 FIFO slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue decision uses only registered occupancy so that rdy_i never reaches
  // the ROM address/enable; counting the in-flight word reserves its slot.
  always_comb begin
    pending = {1'b0, fifo_cnt} + {2'b00, inflight};
    accept  = (state == IDLE) && bus.start_i;
    issue   = (state == READ) && (remaining != '0) && (pending < 3'd3);
    push    = inflight;
    pop     = (fifo_cnt != 2'd0) && bus.rdy_i;
    finish  = (state == DRAIN) && !inflight &&
              ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));
  end

  // Burst sequencing: latch the request, walk the address, wait for the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.len_i != '0) begin
              state     <= READ;
              addr      <= bus.base_addr_i;
              remaining <= bus.len_i;
              busy      <= 1'b1;
            end else begin
              // empty burst: completes without touching the ROM
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            // address wraps naturally at the top of the ROM
            addr      <= addr + Addr_Width'(1);
            remaining <= remaining - (Addr_Width + 1)'(1);
            if (remaining == (Addr_Width + 1)'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (finish) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Track the read whose data lands next cycle and keep output enable low
  // from the first issue until the final capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      oen_hold <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        oen_hold <= 1'b1;
      end else if ((state == DRAIN) && inflight) begin
        oen_hold <= 1'b0;
      end
    end
  end

  // One storage register per FIFO slot; a slot loads only when it is the
  // write target of a capture.
  generate
    for (genvar gi = 0; gi < Fifo_Depth; gi++) begin : g_slot
      // capture ROM data into this slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fifo_mem[gi] <= '0;
        end else if (push && (wr_ptr == 2'(gi))) begin
          fifo_mem[gi] <= bus.rom_data_i;
        end
      end
    end
  endgenerate

  // FIFO pointers and occupancy; simultaneous push and pop leave the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef ROM_BURST_RD_CHKSUM_EN
  logic [Word_Width-1:0] chksum;

  // Running sum of transferred words, restarted by each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum <= '0;
    end else if (accept) begin
      chksum <= '0;
    end else if (pop) begin
      chksum <= chksum + bus.data_o;
    end
  end

  assign bus.chksum_o = chksum;
`endif

  // Outputs: status and stream come straight from registers; the ROM
  // enables decode registered state only.
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;
  assign bus.rom_cen_o  = ~issue;
  assign bus.rom_oen_o  = ~(issue | oen_hold);
  assign bus.rom_addr_o = addr;
  assign bus.val_o      = (fifo_cnt != 2'd0);
  assign bus.data_o     = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_rom_burst_rd.sv
// tb_rom_burst_rd: directed bench for rom_burst_rd with a synchronous ROM
// model (ROM[i] = i*3) that drives a poison word whenever no read is due.
module tb_rom_burst_rd;

  localparam int WW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rom_burst_rd_if #(.Word_Width(WW), .Addr_Width(AW)) bus ();

  rom_burst_rd #(.Word_Width(WW), .Addr_Width(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // ROM model: registered read, poison data when not selected
  logic [31:0] rom [0:255];
  logic [31:0] rom_q   = 32'h0;
  logic        rom_vld = 1'b0;

  always @(posedge clk) begin
    if (!bus.rom_cen_o) begin
      rom_q   <= rom[bus.rom_addr_o];
      rom_vld <= 1'b1;
    end else begin
      rom_vld <= 1'b0;
    end
  end

  assign bus.rom_data_i = (!bus.rom_oen_o && rom_vld) ? rom_q : 32'hDEAD_BEEF;

  int errors = 0;
  int checks = 0;

  // monitor state, sampled on the falling edge
  int          cyc = 0;
  int          n_issue, n_xfer, done_cnt, done_cyc, first_xfer_cyc, last_xfer_cyc;
  int          max_out, busy_cnt, oen_cnt;
  logic [31:0] got_q [$];
  logic [7:0]  addr_q [$];
  logic [31:0] chk_at_done;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (!bus.rom_cen_o) begin
        addr_q.push_back(bus.rom_addr_o);
        n_issue++;
      end
      if (n_issue - n_xfer > max_out) max_out = n_issue - n_xfer;
      if (!bus.rom_oen_o) oen_cnt++;
      if (bus.busy_o) busy_cnt++;
      if (bus.val_o && bus.rdy_i) begin
        got_q.push_back(bus.data_o);
        if (n_xfer == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        n_xfer++;
        $display("xfer cyc=%0d data=%h", cyc, bus.data_o);
      end
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
`ifdef ROM_BURST_RD_CHKSUM_EN
        chk_at_done = bus.chksum_o;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_issue = 0; n_xfer = 0; done_cnt = 0; done_cyc = -1;
    first_xfer_cyc = -1; last_xfer_cyc = -1; max_out = 0;
    busy_cnt = 0; oen_cnt = 0; chk_at_done = '0;
    got_q.delete();
    addr_q.delete();
  endtask

  // drives a one-cycle start; t0 is the falling-edge count at the sampling edge
  task automatic start_burst(input logic [7:0] base, input logic [8:0] len, output int t0);
    bus.start_i     = 1'b1;
    bus.base_addr_i = base;
    bus.len_i       = len;
    tick();
    bus.start_i = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    checks++; if (bus.rom_cen_o !== 1'b1) begin errors++; $display("FAIL reset_cen: got %b want 1", bus.rom_cen_o); end
    checks++; if (bus.rom_oen_o !== 1'b1) begin errors++; $display("FAIL reset_oen: got %b want 1", bus.rom_oen_o); end
    checks++; if (bus.rom_addr_o !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", bus.rom_addr_o); end
    checks++; if (bus.val_o !== 1'b0) begin errors++; $display("FAIL reset_val: got %b want 0", bus.val_o); end
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
    rst = 1'b0;
    tick();
    clear_mon();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int t0;
    logic [31:0] exp;
    clear_mon();
    bus.rdy_i = 1'b1;
    start_burst(8'h10, 9'd4, t0);
    for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL basic_word_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      exp = 32'h30 + 32'(3 * i);
      checks++; if (got_q[i] !== exp) begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, got_q[i], exp); end
    end
    checks++; if (first_xfer_cyc !== t0 + 3) begin errors++; $display("FAIL basic_first_latency: got %0d want %0d", first_xfer_cyc - t0, 3); end
    checks++; if (last_xfer_cyc !== t0 + 6) begin errors++; $display("FAIL basic_throughput: last at %0d want %0d", last_xfer_cyc - t0, 6); end
    checks++; if (done_cyc !== t0 + 7) begin errors++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc - t0, 7); end
    checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 6", busy_cnt); end
    checks++; if (oen_cnt !== 5) begin errors++; $display("FAIL basic_oen_cycles: got %0d want 5", oen_cnt); end
    checks++; if (n_issue !== 4 || addr_q[0] !== 8'h10 || addr_q[3] !== 8'h13) begin
      errors++; $display("FAIL basic_addr: issues %0d first %h last %h want 4 10 13", n_issue, addr_q[0], addr_q[n_issue > 0 ? n_issue - 1 : 0]);
    end
    $display("test_basic: %0d words", got_q.size());
  endtask

  task automatic test_wrap();
    int t0;
    logic [7:0]  exp_a [4];
    logic [31:0] exp_d [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    exp_d[0] = 32'h2FA; exp_d[1] = 32'h2FD; exp_d[2] = 32'h0; exp_d[3] = 32'h3;
    clear_mon();
    bus.rdy_i = 1'b1;
    start_burst(8'hFE, 9'd4, t0);
    for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
    tick();
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
    checks++; if (addr_q.size() !== 4) begin errors++; $display("FAIL wrap_issue_count: got %0d want 4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr_q[i], exp_a[i]); end
    end
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL wrap_word_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_d[i]) begin errors++; $display("FAIL wrap_word%0d: got %h want %h", i, got_q[i], exp_d[i]); end
    end
    $display("test_wrap: %0d words", got_q.size());
  endtask

  task automatic test_backpressure();
    int t0;
    int k;
    logic [31:0] pat;
    logic [31:0] exp;
    pat = 32'b1011_0110_1110_0101_1101_0011_0111_1010;
    clear_mon();
    bus.rdy_i = 1'b0;
    start_burst(8'h20, 9'd16, t0);
    k = 0;
    while (k < 300 && done_cnt == 0) begin
      bus.rdy_i = (k >= 6 && k < 11) ? 1'b0 : pat[k % 32];
      tick();
      k++;
    end
    bus.rdy_i = 1'b1;
    repeat (3) tick();
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL bp_word_count: got %0d want 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      exp = 32'(3 * (32 + i));
      checks++; if (got_q[i] !== exp) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp); end
    end
    checks++; if (max_out > 3) begin errors++; $display("FAIL bp_occupancy: got %0d want <= 3", max_out); end
    checks++; if (n_issue !== 16) begin errors++; $display("FAIL bp_issue_count: got %0d want 16", n_issue); end
    $display("test_backpressure: %0d words, max outstanding %0d", got_q.size(), max_out);
  endtask

  task automatic test_len_zero();
    int t0;
    clear_mon();
    bus.rdy_i = 1'b1;
    start_burst(8'h33, 9'd0, t0);
    repeat (5) tick();
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== t0 + 1) begin errors++; $display("FAIL zero_done_time: got %0d want 1", done_cyc - t0); end
    checks++; if (n_issue !== 0) begin errors++; $display("FAIL zero_rom_access: got %0d want 0", n_issue); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL zero_busy: got %0d want 0", busy_cnt); end
    $display("test_len_zero: done after %0d cycle(s)", done_cyc - t0);
  endtask

  task automatic test_start_ignored();
    int t0;
    logic [31:0] exp;
    clear_mon();
    bus.rdy_i = 1'b1;
    start_burst(8'h40, 9'd4, t0);
    tick();
    bus.start_i = 1'b1; bus.base_addr_i = 8'h00; bus.len_i = 9'd3;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
    repeat (5) tick();
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
    checks++; if (n_issue !== 4) begin errors++; $display("FAIL ign_issue_count: got %0d want 4", n_issue); end
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL ign_word_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      exp = 32'(3 * (64 + i));
      checks++; if (got_q[i] !== exp) begin errors++; $display("FAIL ign_word%0d: got %h want %h", i, got_q[i], exp); end
    end
    $display("test_start_ignored: %0d words", got_q.size());
  endtask

  task automatic test_reset_midburst();
    int t0;
    clear_mon();
    bus.rdy_i = 1'b1;
    start_burst(8'h50, 9'd8, t0);
    for (int i = 0; i < 40 && n_xfer < 2; i++) tick();
    checks++; if (n_xfer !== 2) begin errors++; $display("FAIL mid_reach_2nd: got %0d want 2", n_xfer); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.rom_cen_o !== 1'b1) begin errors++; $display("FAIL mid_cen: got %b want 1", bus.rom_cen_o); end
    checks++; if (bus.rom_oen_o !== 1'b1) begin errors++; $display("FAIL mid_oen: got %b want 1", bus.rom_oen_o); end
    checks++; if (bus.rom_addr_o !== 8'h00) begin errors++; $display("FAIL mid_addr: got %h want 00", bus.rom_addr_o); end
    checks++; if (bus.val_o !== 1'b0) begin errors++; $display("FAIL mid_val: got %b want 0", bus.val_o); end
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL mid_data: got %h want 0", bus.data_o); end
    clear_mon();
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
    checks++; if (n_issue !== 0) begin errors++; $display("FAIL mid_no_reads: got %0d want 0", n_issue); end
    $display("test_reset_midburst: aborted after 2 words");
  endtask

`ifdef ROM_BURST_RD_CHKSUM_EN
  task automatic test_chksum();
    int t0;
    rom[8'h80] = 32'hFFFF_FFFF;
    rom[8'h81] = 32'h0000_0002;
    clear_mon();
    bus.rdy_i = 1'b1;
    start_burst(8'h80, 9'd2, t0);
    for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL chk_done_count: got %0d want 1", done_cnt); end
    checks++; if (chk_at_done !== 32'h1) begin errors++; $display("FAIL chk_at_done: got %h want 00000001", chk_at_done); end
    checks++; if (bus.chksum_o !== 32'h1) begin errors++; $display("FAIL chk_stable: got %h want 00000001", bus.chksum_o); end
    rom[8'h80] = 32'(3 * 128);
    rom[8'h81] = 32'(3 * 129);
    $display("test_chksum: chksum=%h", chk_at_done);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'(3 * i);
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.len_i       = '0;
    bus.rdy_i       = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_ignored();
`ifdef ROM_BURST_RD_CHKSUM_EN
    test_chksum();
`endif
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
